// File: rtl/j_pow_graph_if.sv
// ============================================================================
// Module      : j_pow_graph_if
// Description : Start/argument/end handshake bundle for the j_pow_graph power unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface j_pow_graph_if;
  logic        start_in;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] x_din;
  logic        x_valid_in;
  logic        x_ready_out;
  logic [31:0] n_din;
  logic        n_valid_in;
  logic        n_ready_out;
  logic [31:0] end_out;
  logic        end_valid;
  logic        end_ready;

  modport master (
    output start_in, start_valid, x_din, x_valid_in, n_din, n_valid_in, end_ready,
    input  start_ready, x_ready_out, n_ready_out, end_out, end_valid
  );

  modport slave (
    input  start_in, start_valid, x_din, x_valid_in, n_din, n_valid_in, end_ready,
    output start_ready, x_ready_out, n_ready_out, end_out, end_valid
  );
endinterface

`default_nettype wire

// File: rtl/j_pow_graph.sv
// ============================================================================
// Module      : j_pow_graph
// Description : end_out = x^n (low 32 bits) by repeated multiplication.
//               Optional macro JPOW_ARG_HANDSHAKE_EN gates accept on x/n valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module j_pow_graph (
  input  wire           clk,
  input  wire           rst,
  j_pow_graph_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic        [31:0] r_xr;
  logic signed [31:0] r_nr;
  logic        [31:0] r_acc;
  logic               r_start_ready;
  logic               r_end_valid;
  logic        [31:0] r_end_out;

  logic               w_args_ok;
  logic               w_accept;

`ifdef JPOW_ARG_HANDSHAKE_EN
  assign w_args_ok = bus.x_valid_in & bus.n_valid_in;
`else
  logic w_unused_arg_valid;
  assign w_unused_arg_valid = bus.x_valid_in & bus.n_valid_in;
  assign w_args_ok          = 1'b1;
`endif

  assign w_accept = (r_state == S_IDLE) & bus.start_valid & bus.start_in & w_args_ok;

  // Outputs are registered and state-decoded so end_valid never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_xr          <= 32'd0;
      r_nr          <= 32'sd0;
      r_acc         <= 32'd0;
      r_start_ready <= 1'b1;
      r_end_valid   <= 1'b0;
      r_end_out     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_xr          <= bus.x_din;
            r_nr          <= $signed(bus.n_din);
            r_acc         <= 32'd1;
            r_start_ready <= 1'b0;
            r_state       <= S_LOOP;
          end
        end
        S_LOOP: begin
          if (r_nr > 32'sd0) begin
            r_acc <= r_acc * r_xr;
            r_nr  <= r_nr - 32'sd1;
          end else begin
            r_end_valid <= 1'b1;
            r_end_out   <= r_acc;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.end_ready) begin
            r_end_valid   <= 1'b0;
            r_end_out     <= 32'd0;
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_end_valid   <= 1'b0;
          r_end_out     <= 32'd0;
          r_start_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.x_ready_out = r_start_ready;
  assign bus.n_ready_out = r_start_ready;
  assign bus.end_valid   = r_end_valid;
  assign bus.end_out     = r_end_out;

endmodule

`default_nettype wire

// File: tb/tb_j_pow_graph.sv
// ============================================================================
// Module      : tb_j_pow_graph
// Description : Directed self-checking bench for j_pow_graph.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_j_pow_graph;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  j_pow_graph_if bus ();

  j_pow_graph dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Square-and-multiply reference, independent of the unit's iteration order.
  function automatic logic [31:0] pow32(input logic [31:0] x, input logic signed [31:0] n);
    logic [31:0] res;
    logic [31:0] base;
    logic [31:0] e;
    res  = 32'd1;
    base = x;
    e    = (n > 0) ? n : 32'd0;
    while (e != 0) begin
      if (e[0]) res = res * base;
      base = base * base;
      e    = e >> 1;
    end
    return res;
  endfunction

  task automatic run_pow(input logic [31:0] x, input logic [31:0] n,
                         input logic [31:0] exp, input int hold, input string tag);
    int cnt;
    int lat;
    lat = ($signed(n) > 0) ? int'(n) + 1 : 1;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_in    = 1'b1;
    bus.x_din       = x;
    bus.n_din       = n;
    bus.x_valid_in  = 1'b1;
    bus.n_valid_in  = 1'b1;
    bus.end_ready   = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      cnt++;
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.x_din       = 32'h5a5a_5a5a;
    bus.n_din       = 32'd7;
    while (!bus.end_valid && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_valid"}, {31'd0, bus.end_valid}, 32'd1);
    check({tag, "_latency"}, 32'(cnt), 32'(lat));
    check({tag, "_result"}, bus.end_out, exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drop"}, {31'd0, bus.end_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, bus.start_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] rn;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    bus.start_in    = 1'b0;
    bus.start_valid = 1'b0;
    bus.x_din       = 32'd0;
    bus.n_din       = 32'd0;
    bus.x_valid_in  = 1'b0;
    bus.n_valid_in  = 1'b0;
    bus.end_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
    check("rst_x_ready", {31'd0, bus.x_ready_out}, 32'd1);
    check("rst_n_ready", {31'd0, bus.n_ready_out}, 32'd1);
    check("rst_end_valid", {31'd0, bus.end_valid}, 32'd0);
    check("rst_end_out", bus.end_out, 32'd0);
    rst = 1'b1;

    // start_valid held for two edges must yield a single result
    run_pow(32'd2, 32'd3, 32'd8, 2, "p2_3_hold");
    repeat (4) begin
      @(negedge clk);
      check("no_second_result", {31'd0, bus.end_valid}, 32'd0);
    end

    run_pow(32'd3, 32'd5, 32'd243, 1, "p3_5");
    run_pow(32'd7, 32'd0, 32'd1, 1, "p7_0");
    run_pow(32'd5, -32'sd4, 32'd1, 1, "p5_m4");
    run_pow(32'd200, 32'd20, 32'd0, 1, "p200_20");
    run_pow(32'd199, 32'd20, pow32(32'd199, 32'sd20), 1, "p199_20");
    for (int k = 0; k < 10; k++) begin
      rx = 32'($urandom_range(1, 200));
      rn = 32'($urandom_range(1, 20));
      run_pow(rx, rn, pow32(rx, rn), 1, "rand");
    end

    // Back-pressure: result holds while end_ready is low
    @(negedge clk);
    bus.end_ready   = 1'b0;
    bus.start_valid = 1'b1;
    bus.start_in    = 1'b1;
    bus.x_din       = 32'd3;
    bus.n_din       = 32'd2;
    @(negedge clk);
    bus.start_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.end_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.end_valid}, 32'd1);
      check("bp_out", bus.end_out, 32'd9);
    end
    bus.end_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {31'd0, bus.end_valid}, 32'd0);
    check("bp_release_out", bus.end_out, 32'd0);
    run_pow(32'd2, 32'd3, 32'd8, 1, "bp_next");

    // Reset in the middle of a long computation
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_in    = 1'b1;
    bus.x_din       = 32'd2;
    bus.n_din       = 32'd10;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, bus.start_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.end_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.start_ready}, 32'd1);
    check("mid_rst_out", bus.end_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_pow(32'd2, 32'd3, 32'd8, 1, "after_rst");

`ifdef JPOW_ARG_HANDSHAKE_EN
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_in    = 1'b1;
    bus.x_valid_in  = 1'b0;
    bus.n_valid_in  = 1'b1;
    bus.x_din       = 32'd4;
    bus.n_din       = 32'd3;
    repeat (3) begin
      @(negedge clk);
      check("hs_no_accept", {31'd0, bus.start_ready}, 32'd1);
    end
    bus.x_valid_in = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    check("hs_accept", {31'd0, bus.start_ready}, 32'd0);
    for (int i = 0; i < 20 && !bus.end_valid; i++) @(negedge clk);
    check("hs_result", bus.end_out, 32'd64);
    @(negedge clk);
`else
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_in    = 1'b1;
    bus.x_valid_in  = 1'b0;
    bus.n_valid_in  = 1'b0;
    bus.x_din       = 32'd4;
    bus.n_din       = 32'd3;
    @(negedge clk);
    bus.start_valid = 1'b0;
    check("nohs_accept", {31'd0, bus.start_ready}, 32'd0);
    for (int i = 0; i < 20 && !bus.end_valid; i++) @(negedge clk);
    check("nohs_result", bus.end_out, 32'd64);
    @(negedge clk);
`endif

    // start_in must be 1 for an accept
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_in    = 1'b0;
    bus.x_valid_in  = 1'b1;
    bus.n_valid_in  = 1'b1;
    @(negedge clk);
    check("start_in_zero", {31'd0, bus.start_ready}, 32'd1);
    bus.start_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
